// File: rtl/key_event_encoder.sv
// Playback-side encoder: serializes note-vector changes into make/break key events.
// Optional KEY_ENC_ALL_OFF_EN adds the all_off_i port and a pending zero-vector pass.
module key_event_encoder #(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [47:0]  note_vec_i,
   input  logic         note_load_i,
`ifdef KEY_ENC_ALL_OFF_EN
   input  logic         all_off_i,
`endif
   output logic         load_ready_o,
   output logic [511:0] key_down_o,
   output logic [8:0]   last_change_o,
   output logic         key_valid_o
);

   localparam int unsigned NOTES  = 48;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned GAP_W  = 8;
   localparam int unsigned CODE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   logic [1:0]        state_q,  state_d;
   logic [IDX_W-1:0]  idx_q,    idx_d;
   logic [GAP_W-1:0]  gap_q,    gap_d;
   logic [NOTES-1:0]  target_q, target_d;
   logic [NOTES-1:0]  held_q,   held_d;
   logic [CODE_W-1:0] code_q,   code_d;
   logic              key_valid_q, key_valid_d;
   logic              load_ready_q;
   logic              end_pass;
`ifdef KEY_ENC_ALL_OFF_EN
   logic              pending_q, pending_d;
`endif

   // Note index to keyboard scan code.
   function automatic logic [CODE_W-1:0] note_code(input logic [IDX_W-1:0] idx);
      logic [CODE_W-1:0] c;
      case (idx)
         6'd0:  c = 8'h12;  6'd1:  c = 8'h1A;  6'd2:  c = 8'h22;  6'd3:  c = 8'h21;
         6'd4:  c = 8'h2A;  6'd5:  c = 8'h32;  6'd6:  c = 8'h31;  6'd7:  c = 8'h3A;
         6'd8:  c = 8'h41;  6'd9:  c = 8'h49;  6'd10: c = 8'h4A;  6'd11: c = 8'h59;
         6'd12: c = 8'h1C;  6'd13: c = 8'h1B;  6'd14: c = 8'h23;  6'd15: c = 8'h2B;
         6'd16: c = 8'h34;  6'd17: c = 8'h33;  6'd18: c = 8'h3B;  6'd19: c = 8'h42;
         6'd20: c = 8'h4B;  6'd21: c = 8'h4C;  6'd22: c = 8'h52;  6'd23: c = 8'h5A;
         6'd24: c = 8'h15;  6'd25: c = 8'h1D;  6'd26: c = 8'h24;  6'd27: c = 8'h2D;
         6'd28: c = 8'h2C;  6'd29: c = 8'h35;  6'd30: c = 8'h3C;  6'd31: c = 8'h43;
         6'd32: c = 8'h44;  6'd33: c = 8'h4D;  6'd34: c = 8'h54;  6'd35: c = 8'h5B;
         6'd36: c = 8'h16;  6'd37: c = 8'h1E;  6'd38: c = 8'h26;  6'd39: c = 8'h25;
         6'd40: c = 8'h2E;  6'd41: c = 8'h36;  6'd42: c = 8'h3D;  6'd43: c = 8'h3E;
         6'd44: c = 8'h46;  6'd45: c = 8'h45;  6'd46: c = 8'h4E;  6'd47: c = 8'h55;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Next-state logic: one index per SCAN cycle, GAP_CYCLES of EMIT per event.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      target_d    = target_q;
      held_d      = held_q;
      code_d      = code_q;
      key_valid_d = 1'b0;
      end_pass    = 1'b0;
`ifdef KEY_ENC_ALL_OFF_EN
      pending_d   = pending_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef KEY_ENC_ALL_OFF_EN
            if (all_off_i) begin
               target_d = '0;
               idx_d    = '0;
               state_d  = ST_SCAN;
            end else
`endif
            if (note_load_i) begin
               target_d = note_vec_i;
               idx_d    = '0;
               state_d  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (target_q[idx_q] != held_q[idx_q]) begin
               held_d[idx_q] = target_q[idx_q];
               code_d        = note_code(idx_q);
               key_valid_d   = 1'b1;
               gap_d         = GAP_LOAD;
               state_d       = ST_EMIT;
            end else if (idx_q == LAST_IDX) begin
               end_pass = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_EMIT: begin
            if (gap_q == '0) begin
               if (idx_q == LAST_IDX) begin
                  end_pass = 1'b1;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_SCAN;
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef KEY_ENC_ALL_OFF_EN
      if ((state_q != ST_IDLE) && all_off_i) begin
         pending_d = 1'b1;
      end
`endif

      // A pending all-off chains a zero-vector pass without passing through IDLE.
      if (end_pass) begin
         state_d = ST_IDLE;
`ifdef KEY_ENC_ALL_OFF_EN
         if (pending_d) begin
            state_d   = ST_SCAN;
            idx_d     = '0;
            target_d  = '0;
            pending_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         gap_q        <= '0;
         target_q     <= '0;
         held_q       <= '0;
         code_q       <= '0;
         key_valid_q  <= 1'b0;
         load_ready_q <= 1'b1;
`ifdef KEY_ENC_ALL_OFF_EN
         pending_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         gap_q        <= gap_d;
         target_q     <= target_d;
         held_q       <= held_d;
         code_q       <= code_d;
         key_valid_q  <= key_valid_d;
         load_ready_q <= (state_d == ST_IDLE);
`ifdef KEY_ENC_ALL_OFF_EN
         pending_q    <= pending_d;
`endif
      end
   end

   // key_down is a fixed rewiring of the held register onto scan-code positions.
   always_comb begin
      key_down_o = '0;
      for (int i = 0; i < NOTES; i++) begin
         key_down_o[{1'b0, note_code(IDX_W'(i))}] = held_q[i];
      end
   end

   assign load_ready_o  = load_ready_q;
   assign last_change_o = {1'b0, code_q};
   assign key_valid_o   = key_valid_q;

endmodule
